// File: rtl/viterbi_puncture_if.sv
// -----------------------------------------------------------------------------
// viterbi_puncture_if
//   Handshake bundle for the puncturing/serialising stage.
//   Input side : i_data/i_valid/i_sop in, o_ready back out.
//   Output side: o_data/o_valid out, i_ready back in.
//   o_phase is a debug view of the current puncture phase.
//   Signal names follow the stage's own port view (i_* enters the stage).
// Modports
//   slave  : the puncture stage itself
//   master : whatever drives the stage (encoder side + downstream sink)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface viterbi_puncture_if #(
   parameter int unsigned p_phase_w = 2
) ();

   logic [1:0]           i_data;   // [0]=g0, [1]=g1
   logic                 i_valid;
   logic                 i_sop;
   logic                 o_ready;
   logic                 o_data;
   logic                 o_valid;
   logic                 i_ready;
   logic [p_phase_w-1:0] o_phase;

   modport slave (
      input  i_data, i_valid, i_sop, i_ready,
      output o_ready, o_data, o_valid, o_phase
   );

   modport master (
      output i_data, i_valid, i_sop, i_ready,
      input  o_ready, o_data, o_valid, o_phase
   );

endinterface

// File: rtl/viterbi_puncture.sv
// -----------------------------------------------------------------------------
// viterbi_puncture
//   Puncturing + serialising stage behind a rate-1/2 convolutional encoder.
//   Each accepted coded pair {g1,g0} is filtered by a periodic keep-mask; the
//   surviving bits (g0 first, then g1) are written into a small bit-FIFO and
//   streamed out one bit per cycle.
//
// Parameters
//   p_period     puncture period in input pairs (1..16)
//   p_mask_0     keep-mask for g0, bit k applies to phase k
//   p_mask_1     keep-mask for g1, bit k applies to phase k
//   p_fifo_depth bit-FIFO depth, power of two, >= 4
//
// Ports
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   bus        viterbi_puncture_if.slave
//                i_data/i_valid/i_sop  coded pair in (i_sop forces phase 0)
//                o_ready               room for a full pair (2 bits)
//                o_data/o_valid        serial punctured bit out
//                i_ready               downstream accepts o_data
//                o_phase               current puncture phase (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module viterbi_puncture #(
   parameter int unsigned p_period     = 2,
   parameter logic [15:0] p_mask_0     = 16'b11,
   parameter logic [15:0] p_mask_1     = 16'b01,
   parameter int unsigned p_fifo_depth = 8
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   viterbi_puncture_if.slave  bus
);

   localparam int unsigned c_phase_w = $clog2(p_period) + 1;
   localparam int unsigned c_ptr_w   = $clog2(p_fifo_depth);
   localparam int unsigned c_cnt_w   = c_ptr_w + 1;

   // Accepting only when two free slots exist means a pair is never split.
   localparam logic [c_cnt_w-1:0]   c_ready_max  = c_cnt_w'(p_fifo_depth - 2);
   localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(p_period - 1);

   logic [c_phase_w-1:0]    phase;
   logic [c_phase_w-1:0]    eff_phase;
   logic [c_phase_w-1:0]    next_phase;
   logic [p_fifo_depth-1:0] mem;
   logic [c_ptr_w-1:0]      wr_ptr;
   logic [c_ptr_w-1:0]      rd_ptr;
   logic [c_ptr_w-1:0]      wr1_addr;
   logic [c_cnt_w-1:0]      count;
   logic                    accept;
   logic                    pop;
   logic                    keep0;
   logic                    keep1;
   logic                    wr0;
   logic                    wr1;
   logic [1:0]              nkeep;

   // ---------------------------------------------------------------------------
   // Handshakes. Both ready and valid come from the registered count only, so
   // there is no combinational i_valid->o_valid or i_ready->o_ready path.
   // Reset gates o_ready directly so nothing is accepted while it is held.
   // ---------------------------------------------------------------------------
   assign bus.o_ready = i_reset_n & (count <= c_ready_max);
   assign bus.o_valid = (count != '0);
   assign bus.o_data  = bus.o_valid & mem[rd_ptr];
   assign bus.o_phase = phase;

   assign accept = bus.i_valid & bus.o_ready;
   assign pop    = bus.o_valid & bus.i_ready;

   // ---------------------------------------------------------------------------
   // Puncture decision for the pair presented this cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves one unassigned would infer a latch.
      keep0     = 1'b0;
      keep1     = 1'b0;
      eff_phase = bus.i_sop ? '0 : phase;
      for (int k = 0; k < int'(p_period); k++) begin
         if (eff_phase == c_phase_w'(k)) begin
            keep0 = p_mask_0[k];
            keep1 = p_mask_1[k];
         end
      end
      next_phase = (eff_phase == c_last_phase) ? '0 : eff_phase + 1'b1;
   end

   assign wr0      = accept & keep0;
   assign wr1      = accept & keep1;
   assign nkeep    = {1'b0, wr0} + {1'b0, wr1};
   // g1 lands behind g0 when both survive, otherwise it takes the tail slot.
   assign wr1_addr = wr_ptr + c_ptr_w'(wr0);

   // ---------------------------------------------------------------------------
   // Control state: phase, pointers, occupancy.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of block ordering.
      if (!i_reset_n) begin
         phase  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            phase <= next_phase;
         end
         wr_ptr <= wr_ptr + c_ptr_w'(nkeep);
         rd_ptr <= rd_ptr + c_ptr_w'(pop);
         count  <= count + c_cnt_w'(nkeep) - c_cnt_w'(pop);
      end
   end

   // ---------------------------------------------------------------------------
   // Bit storage.
   // ---------------------------------------------------------------------------
   // NOTE: the storage array is deliberately not reset; occupancy is tracked by
   // count, and o_data is masked by o_valid, so stale contents are never seen.
   always_ff @(posedge i_clk) begin
      if (wr0) begin
         mem[wr_ptr] <= bus.i_data[0];
      end
      if (wr1) begin
         mem[wr1_addr] <= bus.i_data[1];
      end
   end

endmodule
